// File: rtl/memory_stage_nlane.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage_nlane
//  Description : LANES-wide memory stage between execute and writeback.
//                Each lane may perform a byte/half/word load or store against
//                one shared little-endian, byte-addressed data memory. Loads
//                see stores made by older (lower-index) lanes in the same
//                cycle. Misaligned accesses are flagged and suppressed. The
//                per-lane result (ALU value or extended load data) is
//                registered with a valid bit.
//  Ports       : clk, rst_n (sync, active low), stall
//                valid_in/ResultSrc/MemWrite/MemUnsigned [LANES]
//                MemSize [2*LANES]   (00 byte, 01 half, 1x word)
//                ALUResult/wdata [LANES*DATA_WIDTH], lane k at [k*32 +: 32]
//                Result [LANES*DATA_WIDTH], valid_out/misalign_err [LANES]
//  Revision    : 1.0  initial release
// ============================================================================
module memory_stage_nlane #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 2,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic [LANES-1:0]            valid_in,
    input  logic [LANES-1:0]            ResultSrc,
    input  logic [LANES-1:0]            MemWrite,
    input  logic [2*LANES-1:0]          MemSize,
    input  logic [LANES-1:0]            MemUnsigned,
    input  logic [LANES*DATA_WIDTH-1:0] ALUResult,
    input  logic [LANES*DATA_WIDTH-1:0] wdata,
    output logic [LANES*DATA_WIDTH-1:0] Result,
    output logic [LANES-1:0]            valid_out,
    output logic [LANES-1:0]            misalign_err
);

    localparam int C_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int C_NB = DATA_WIDTH / 8;

    // Shared data memory; not reset.
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    // Per-lane decode
    logic [C_AW-1:0]       w_idx   [LANES];
    logic [1:0]            w_off   [LANES];
    logic [C_NB-1:0]       w_be    [LANES];
    logic [DATA_WIDTH-1:0] w_sdata [LANES];
    logic [LANES-1:0]      w_active;
    logic [LANES-1:0]      w_mis;
    logic [LANES-1:0]      w_store;
    logic [LANES-1:0]      w_err;
    logic [LANES*DATA_WIDTH-1:0] w_result;

    always_comb begin
        logic [DATA_WIDTH-1:0] v_load;
        logic [DATA_WIDTH-1:0] v_sh;
        logic [DATA_WIDTH-1:0] v_ext;
        logic                  v_sign;

        v_load   = '0;
        v_sh     = '0;
        v_ext    = '0;
        v_sign   = 1'b0;
        w_result = '0;

        // Address decode, alignment, byte enables and positioned store data.
        for (int k = 0; k < LANES; k++) begin
            w_off[k]    = ALUResult[k*DATA_WIDTH +: 2];
            w_idx[k]    = ALUResult[k*DATA_WIDTH+2 +: C_AW];
            w_active[k] = valid_in[k] & ~stall;

            case (MemSize[2*k +: 2])
                2'b00:   w_mis[k] = 1'b0;
                2'b01:   w_mis[k] = w_off[k][0];
                default: w_mis[k] = (w_off[k] != 2'b00);
            endcase

            case (MemSize[2*k +: 2])
                2'b00:   w_be[k] = C_NB'(4'b0001) << w_off[k];
                2'b01:   w_be[k] = C_NB'(4'b0011) << w_off[k];
                default: w_be[k] = '1;
            endcase

            w_sdata[k] = wdata[k*DATA_WIDTH +: DATA_WIDTH] << {w_off[k], 3'b000};

            // Alignment only matters when the lane actually touches memory.
            w_err[k]   = w_active[k] & (MemWrite[k] | ResultSrc[k]) & w_mis[k];
            w_store[k] = w_active[k] & MemWrite[k] & ~w_mis[k];
        end

        // Load path: memory word overlaid by older lanes' stores to the same
        // word; iterating j upward lets the youngest older store win per byte.
        for (int k = 0; k < LANES; k++) begin
            v_load = r_mem[w_idx[k]];
            for (int j = 0; j < LANES; j++) begin
                if ((j < k) && w_store[j] && (w_idx[j] == w_idx[k])) begin
                    for (int b = 0; b < C_NB; b++) begin
                        if (w_be[j][b]) begin
                            v_load[b*8 +: 8] = w_sdata[j][b*8 +: 8];
                        end
                    end
                end
            end

            v_sh = v_load >> {w_off[k], 3'b000};
            case (MemSize[2*k +: 2])
                2'b00: begin
                    v_sign = ~MemUnsigned[k] & v_sh[7];
                    v_ext  = {{(DATA_WIDTH-8){v_sign}}, v_sh[7:0]};
                end
                2'b01: begin
                    v_sign = ~MemUnsigned[k] & v_sh[15];
                    v_ext  = {{(DATA_WIDTH-16){v_sign}}, v_sh[15:0]};
                end
                default: begin
                    v_sign = 1'b0;
                    v_ext  = v_sh;
                end
            endcase

            // A lane that stores returns its ALU value even if ResultSrc=1.
            if (!w_active[k] || w_err[k]) begin
                w_result[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (MemWrite[k] || !ResultSrc[k]) begin
                w_result[k*DATA_WIDTH +: DATA_WIDTH] = ALUResult[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_result[k*DATA_WIDTH +: DATA_WIDTH] = v_ext;
            end
        end
    end

    // Memory commit; later lanes are written last so they win per byte.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                for (int b = 0; b < C_NB; b++) begin
                    if (w_store[k] && w_be[k][b]) begin
                        r_mem[w_idx[k]][b*8 +: 8] <= w_sdata[k][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Output register; stall freezes it, reset overrides stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Result       <= '0;
            valid_out    <= '0;
            misalign_err <= '0;
        end else if (!stall) begin
            Result       <= w_result;
            valid_out    <= valid_in;
            misalign_err <= w_err;
        end
    end

endmodule
`default_nettype wire

// File: doc/memory_stage_nlane.md
Name: memory_stage_nlane

Overview:
- Parametrised successor to the dual-issue memory stage.
- Serves LANES parallel load/store lanes against one shared byte-addressed data memory, and selects per lane between the ALU result and the load data.
- Adds byte/half/word access with sign or zero extension, in-cycle store-to-load forwarding between lanes, misalignment detection, a stall input and a registered output stage with valid bits.
- Sits between execute and writeback in the multi-issue pipeline.

Parameters:
DATA_WIDTH, 32, word width in bits. Fixed at 32 for the sizing rules below.
LANES, 2, number of issue lanes. Legal values 1 to 4.
MEM_WORDS, 1024, memory depth in 32-bit words. Must be a power of 2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
stall  in  1  1 = hold the stage: no commit, outputs frozen
valid_in  in  LANES  per-lane instruction valid
ResultSrc  in  LANES  per lane: 0 = ALU result, 1 = load data
MemWrite  in  LANES  per-lane store enable
MemSize  in  2*LANES  per lane: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
MemUnsigned  in  LANES  per lane: 1 = zero-extend loads, 0 = sign-extend
ALUResult  in  LANES*DATA_WIDTH  per-lane byte address / ALU value; lane k occupies bits [k*32 +: 32]
wdata  in  LANES*DATA_WIDTH  per-lane store data, LSB-aligned
Result  out  LANES*DATA_WIDTH  registered per-lane result
valid_out  out  LANES  registered valid
misalign_err  out  LANES  registered per-lane misalignment flag

Behaviour:
- Clocking and reset
  - Single clock domain; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - Reset forces Result=0, valid_out=0, misalign_err=0.
  - Memory contents are not reset.
  - Reset dominates stall.
  - A store presented in the same cycle rst_n=0 is not committed.
- Addressing
  - Little-endian, byte addressed.
  - Word index = addr[log2(MEM_WORDS)+1:2]; upper address bits are ignored, so accesses wrap modulo MEM_WORDS*4 bytes.
  - Byte lanes within the word are selected by addr[1:0].
- Lane activity: a lane is active when valid_in=1 and stall=0.
- Misalignment
  - Half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Registered result: misalign_err=1, Result=0, valid_out=1.
  - A misaligned store is suppressed: no memory write.
- Stores
  - Committed on the rising edge ending the cycle (active, MemWrite=1, aligned, rst_n=1).
  - Byte enables are derived from MemSize and addr[1:0]; wdata low bytes are shifted into position.
- Same-cycle conflicts
  - Lane index is program order: lane 0 is oldest.
  - On overlapping store bytes, the highest-index lane wins per byte.
- Load data
  - Comes from memory contents at the start of the cycle, overlaid per byte with store bytes from active lower-index lanes of the same cycle. The highest such lane wins.
  - Stores from the same or higher lanes are never visible to a load in that cycle.
- Result selection (when ResultSrc=1, from the load data)
  - Extract byte/half/word at the offset, then sign- or zero-extend to 32 bits.
  - ResultSrc=0: Result = ALUResult unchanged. MemSize/MemUnsigned are ignored, and no misalignment check is made unless MemWrite=1.
- Latency
  - One cycle: inputs sampled at edge N appear on the outputs after edge N.
  - valid_out = registered valid_in for lanes that were active.
- Stall
  - stall=1 holds Result, valid_out and misalign_err at their previous values.
  - No memory write; inputs are ignored.
- Both ResultSrc=1 and MemWrite=1 on one lane: treat as a store; Result = ALUResult.
- Inactive lane (valid_in=0): no write; registered valid_out=0, Result=0, misalign_err=0.

Test Plan:
- Reset: assert rst_n=0 with stall=1 and an active store to 0x10 -> after edge Result=0, valid_out=0; a later word load of 0x10 returns prior contents, proving no write occurred.
- Sizes/extension: store word 0x8081_F2F3 @0x20, then load byte @0x21 signed -> 0xFFFF_FFF2; unsigned half @0x22 -> 0x0000_8081; word @0x20 -> 0x8081_F2F3.
- Forwarding: lane0 store byte 0xAA @0x40, lane1 load word @0x40 (memory 0x1122_3344) same cycle -> lane1 Result 0x1122_33AA. Reverse lanes -> 0x1122_3344.
- Write conflict: lane0 stores word 0x1111_1111 and lane1 stores half 0x2222 @0x60 same cycle -> later load returns 0x1111_2222.
- Misalign/wrap: word store @0x62 -> misalign_err=1, memory unchanged. Word store @(MEM_WORDS*4+0x8) -> readable at 0x8.
- Stall: active load with stall=1 for 3 cycles -> outputs unchanged, no write. On release, Result appears one cycle later with valid_out=1.
